// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, control bundle and branch-condition helper shared by the BIP CPU.
package bip_pkg;
    localparam int OPW = 5;
    localparam logic [OPW-1:0] OP_HLT = 5'd0, OP_STO = 5'd1, OP_LD = 5'd2, OP_LDI = 5'd3,
                               OP_ADD = 5'd4, OP_ADDI = 5'd5, OP_SUB = 5'd6, OP_SUBI = 5'd7,
                               OP_BEQ = 5'd8, OP_BNE = 5'd9, OP_BGT = 5'd10, OP_BGE = 5'd11,
                               OP_BLT = 5'd12, OP_BLE = 5'd13, OP_JMP = 5'd14, OP_NOT = 5'd15,
                               OP_AND = 5'd16, OP_ANDI = 5'd17, OP_OR = 5'd18, OP_ORI = 5'd19,
                               OP_XOR = 5'd20, OP_XORI = 5'd21, OP_NOP = 5'd31;
    typedef enum logic {RUN, HALT} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_IMM, SRC_ALU} acc_src_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT} alu_op_t;
    typedef struct packed {
        logic     rd;
        logic     wr;
        acc_src_t acc_src;
        alu_op_t  alu_op;
        logic     use_imm;
        logic     wr_acc;
        logic     is_branch;
        logic     is_halt;
    } ctrl_t;
    function automatic logic branch_taken(input logic [OPW-1:0] op, input logic z, input logic n);
        return op == OP_BEQ ? z :
               op == OP_BNE ? !z :
               op == OP_BGT ? (!z && !n) :
               op == OP_BGE ? !n :
               op == OP_BLT ? n :
               op == OP_BLE ? (n || z) :
               op == OP_JMP;
    endfunction
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode to control-bundle decode; unknown opcodes decode as NOP.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPW-1:0] i_opcode,
    output ctrl_t          o_ctrl
);
    always_comb begin
        o_ctrl = '{rd: 1'b0, wr: 1'b0, acc_src: SRC_ALU, alu_op: ALU_ADD,
                   use_imm: 1'b0, wr_acc: 1'b0, is_branch: 1'b0, is_halt: 1'b0};
        case (i_opcode)
            OP_HLT:  o_ctrl.is_halt = 1'b1;
            OP_STO:  o_ctrl.wr = 1'b1;
            OP_LD:   begin o_ctrl.rd = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.acc_src = SRC_MEM; end
            OP_LDI:  begin o_ctrl.wr_acc = 1'b1; o_ctrl.acc_src = SRC_IMM; end
            OP_ADD:  begin o_ctrl.rd = 1'b1; o_ctrl.wr_acc = 1'b1; end
            OP_ADDI: begin o_ctrl.use_imm = 1'b1; o_ctrl.wr_acc = 1'b1; end
            OP_SUB:  begin o_ctrl.rd = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_SUB; end
            OP_SUBI: begin o_ctrl.use_imm = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_SUB; end
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: o_ctrl.is_branch = 1'b1;
            OP_NOT:  begin o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_NOT; end
            OP_AND:  begin o_ctrl.rd = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_AND; end
            OP_ANDI: begin o_ctrl.use_imm = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_AND; end
            OP_OR:   begin o_ctrl.rd = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_OR; end
            OP_ORI:  begin o_ctrl.use_imm = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_OR; end
            OP_XOR:  begin o_ctrl.rd = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_XOR; end
            OP_XORI: begin o_ctrl.use_imm = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.alu_op = ALU_XOR; end
            default: ;
        endcase
    end
endmodule

// File: rtl/bip_cpu_param.sv
// bip_cpu_param: parametrised single-cycle accumulator CPU with Z/N flags, branches, halt and stall.
module bip_cpu_param
    import bip_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 11,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Stall,
    input  logic [OPCODE_WIDTH+ADDR_WIDTH-1:0] Instruction,
    output logic [ADDR_WIDTH-1:0]              InsAddr,
    output logic                               Rd,
    output logic                               Wr,
    output logic [ADDR_WIDTH-1:0]              DataAddr,
    output logic [DATA_WIDTH-1:0]              In_Data,
    input  logic [DATA_WIDTH-1:0]              Out_Data,
    output logic                               Halted
);
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic                    r_z, r_n;
    state_t                  r_state, w_state_next;
    logic [OPCODE_WIDTH-1:0] w_opfield;
    logic [OPW-1:0]          w_op;
    logic [ADDR_WIDTH-1:0]   w_operand, w_pc_next;
    logic [DATA_WIDTH-1:0]   w_imm, w_b, w_alu, w_result;
    logic                    w_run, w_taken;
    ctrl_t                   w_ctrl;

    assign w_opfield = Instruction[ADDR_WIDTH +: OPCODE_WIDTH];
    // Opcodes wider than the defined set decode as NOP when any extra bit is set.
    assign w_op      = (w_opfield >> OPW) == '0 ? w_opfield[OPW-1:0] : OP_NOP;
    assign w_operand = Instruction[ADDR_WIDTH-1:0];
    assign w_imm     = DATA_WIDTH'($signed(w_operand));

    bip_decoder u_dec (.i_opcode(w_op), .o_ctrl(w_ctrl));

    assign w_b      = w_ctrl.use_imm ? w_imm : Out_Data;
    assign w_alu    = w_ctrl.alu_op == ALU_SUB ? r_acc - w_b :
                      w_ctrl.alu_op == ALU_AND ? r_acc & w_b :
                      w_ctrl.alu_op == ALU_OR  ? r_acc | w_b :
                      w_ctrl.alu_op == ALU_XOR ? r_acc ^ w_b :
                      w_ctrl.alu_op == ALU_NOT ? ~r_acc : r_acc + w_b;
    assign w_result = w_ctrl.acc_src == SRC_MEM ? Out_Data :
                      w_ctrl.acc_src == SRC_IMM ? w_imm : w_alu;

    assign w_run     = (r_state == RUN) && !Stall;
    assign w_taken   = w_ctrl.is_branch && branch_taken(w_op, r_z, r_n);
    // HLT keeps the PC on itself so InsAddr points at the halting instruction.
    assign w_pc_next = w_ctrl.is_halt ? r_pc : w_taken ? w_operand : r_pc + ADDR_WIDTH'(1);

    always_comb w_state_next = (w_run && w_ctrl.is_halt) ? HALT : r_state;

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= RUN;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc  <= '0;
            r_acc <= '0;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
        end else if (w_run) begin
            r_pc <= w_pc_next;
            if (w_ctrl.wr_acc) begin
                r_acc <= w_result;
                r_z   <= w_result == '0;
                r_n   <= w_result[DATA_WIDTH-1];
            end
        end
    end

    assign InsAddr  = r_pc;
    assign DataAddr = w_operand;
    assign In_Data  = r_acc;
    assign Rd       = !Reset && (r_state == RUN) && w_ctrl.rd;
    assign Wr       = !Reset && w_run && w_ctrl.wr;
    assign Halted   = r_state == HALT;
endmodule

// File: tb/tb_bip_cpu_param.sv
// tb_bip_cpu_param: directed program checks plus random programs against an instruction-level model.
module tb_bip_cpu_param;
    logic        Clock = 1'b0;
    logic        Reset, Stall, Rd, Wr, Halted;
    logic [15:0] Instruction, In_Data, Out_Data;
    logic [10:0] InsAddr, DataAddr;
    logic [15:0] rom [0:2047];
    logic [15:0] ram [0:2047];
    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;
    assign Instruction = rom[InsAddr];
    assign Out_Data    = ram[DataAddr];

    bip_cpu_param #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .OPCODE_WIDTH(5)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Instruction(Instruction),
        .InsAddr(InsAddr), .Rd(Rd), .Wr(Wr), .DataAddr(DataAddr), .In_Data(In_Data),
        .Out_Data(Out_Data), .Halted(Halted));

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] a);
        return {op, a};
    endfunction

    // One clock; the RAM captures a write strobed just before the edge.
    task automatic tick();
        logic        w;
        logic [10:0] a;
        logic [15:0] d;
        w = Wr; a = DataAddr; d = In_Data;
        @(posedge Clock);
        if (w) ram[a] = d;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) begin rom[i] = 16'hF800; ram[i] = 16'h0000; end
    endtask

    task automatic do_reset();
        Reset = 1'b1; Stall = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        rom[0] = enc(5'd1, 11'h040);
        ram[11'h040] = 16'h1234;
        Reset = 1'b1; Stall = 1'b0;
        #1;
        checks++; if (Wr !== 1'b0) begin errors++; $display("FAIL reset_wr_gate got=%b exp=0", Wr); end
        repeat (3) tick();
        checks++; if (InsAddr !== 11'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", InsAddr); end
        checks++; if (In_Data !== 16'h0000) begin errors++; $display("FAIL reset_acc got=%h exp=0000", In_Data); end
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", Halted); end
        checks++; if (ram[11'h040] !== 16'h1234) begin errors++; $display("FAIL reset_sto_suppressed got=%h exp=1234", ram[11'h040]); end
        rom[0] = 16'h1855;
        rom[1] = enc(5'd10, 11'h040);
        Reset = 1'b0;
        #1;
        checks++; if ({Rd, Wr} !== 2'b00) begin errors++; $display("FAIL ldi_strobes got=%b exp=00", {Rd, Wr}); end
        tick();
        checks++; if (InsAddr !== 11'h001) begin errors++; $display("FAIL ldi_pc got=%h exp=001", InsAddr); end
        checks++; if (In_Data !== 16'h0055) begin errors++; $display("FAIL ldi_acc got=%h exp=0055", In_Data); end
        tick();
        checks++; if (InsAddr !== 11'h040) begin errors++; $display("FAIL bgt_pos got=%h exp=040", InsAddr); end
    endtask

    task automatic test_flags_wrap();
        clear_mem();
        rom[0] = enc(5'd3, 11'h7FF);
        rom[1] = enc(5'd12, 11'h003);
        rom[3] = enc(5'd5, 11'h001);
        rom[4] = enc(5'd8, 11'h200);
        do_reset();
        tick();
        checks++; if (In_Data !== 16'hFFFF) begin errors++; $display("FAIL ldi_sext got=%h exp=ffff", In_Data); end
        tick();
        checks++; if (InsAddr !== 11'h003) begin errors++; $display("FAIL blt_n_set got=%h exp=003", InsAddr); end
        tick();
        checks++; if (In_Data !== 16'h0000) begin errors++; $display("FAIL addi_wrap got=%h exp=0000", In_Data); end
        tick();
        checks++; if (InsAddr !== 11'h200) begin errors++; $display("FAIL beq_z_set got=%h exp=200", InsAddr); end
    endtask

    task automatic test_sto_branch(input logic [10:0] sub);
        logic [10:0] exp_pc;
        exp_pc = (sub == 11'd5) ? 11'h100 : 11'h004;
        clear_mem();
        rom[0] = enc(5'd3, 11'h005);
        rom[1] = enc(5'd1, 11'h010);
        rom[2] = enc(5'd7, sub);
        rom[3] = enc(5'd8, 11'h100);
        do_reset();
        tick();
        checks++; if ({Wr, DataAddr, In_Data} !== {1'b1, 11'h010, 16'h0005}) begin
            errors++; $display("FAIL sto_bus got=%b/%h/%h exp=1/010/0005", Wr, DataAddr, In_Data); end
        tick();
        checks++; if (ram[11'h010] !== 16'h0005) begin errors++; $display("FAIL sto_ram got=%h exp=0005", ram[11'h010]); end
        checks++; if (Wr !== 1'b0) begin errors++; $display("FAIL sto_single_pulse got=%b exp=0", Wr); end
        tick();
        tick();
        checks++; if (InsAddr !== exp_pc) begin errors++; $display("FAIL beq_sub%0d got=%h exp=%h", sub, InsAddr, exp_pc); end
    endtask

    task automatic test_ld_branch();
        clear_mem();
        ram[11'h020] = 16'h8000;
        rom[0] = enc(5'd2, 11'h020);
        rom[1] = enc(5'd12, 11'h050);
        rom[11'h050] = enc(5'd11, 11'h060);
        do_reset();
        checks++; if (Rd !== 1'b1) begin errors++; $display("FAIL ld_rd got=%b exp=1", Rd); end
        tick();
        checks++; if (In_Data !== 16'h8000) begin errors++; $display("FAIL ld_acc got=%h exp=8000", In_Data); end
        tick();
        checks++; if (InsAddr !== 11'h050) begin errors++; $display("FAIL blt_taken got=%h exp=050", InsAddr); end
        tick();
        checks++; if (InsAddr !== 11'h051) begin errors++; $display("FAIL bge_not_taken got=%h exp=051", InsAddr); end
    endtask

    task automatic test_stall();
        clear_mem();
        rom[0] = enc(5'd3, 11'h009);
        rom[1] = enc(5'd1, 11'h030);
        rom[2] = enc(5'd2, 11'h030);
        do_reset();
        tick();
        Stall = 1'b1;
        #1;
        checks++; if (Wr !== 1'b0) begin errors++; $display("FAIL stall_wr got=%b exp=0", Wr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({InsAddr, Wr} !== {11'h001, 1'b0}) begin
                errors++; $display("FAIL stall_hold got=%h/%b exp=001/0", InsAddr, Wr); end
        end
        checks++; if (ram[11'h030] !== 16'h0000) begin errors++; $display("FAIL stall_no_write got=%h exp=0000", ram[11'h030]); end
        Stall = 1'b0;
        #1;
        checks++; if (Wr !== 1'b1) begin errors++; $display("FAIL unstall_wr got=%b exp=1", Wr); end
        tick();
        checks++; if ({InsAddr, ram[11'h030]} !== {11'h002, 16'h0009}) begin
            errors++; $display("FAIL unstall_commit got=%h/%h exp=002/0009", InsAddr, ram[11'h030]); end
        Stall = 1'b1;
        #1;
        checks++; if ({Rd, Wr} !== 2'b10) begin errors++; $display("FAIL stall_rd got=%b exp=10", {Rd, Wr}); end
        Stall = 1'b0;
    endtask

    task automatic test_halt();
        clear_mem();
        rom[0] = enc(5'd3, 11'h033);
        rom[7] = enc(5'd0, 11'h000);
        do_reset();
        repeat (7) tick();
        checks++; if ({InsAddr, Halted} !== {11'h007, 1'b0}) begin
            errors++; $display("FAIL pre_halt got=%h/%b exp=007/0", InsAddr, Halted); end
        tick();
        checks++; if ({InsAddr, Halted} !== {11'h007, 1'b1}) begin
            errors++; $display("FAIL halt_entry got=%h/%b exp=007/1", InsAddr, Halted); end
        rom[7] = enc(5'd1, 11'h005);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({InsAddr, Halted, Rd, Wr, In_Data} !== {11'h007, 3'b100, 16'h0033}) begin
                errors++; $display("FAIL halt_frozen got=%h/%b%b%b/%h exp=007/100/0033", InsAddr, Halted, Rd, Wr, In_Data); end
        end
        checks++; if (ram[11'h005] !== 16'h0000) begin errors++; $display("FAIL halt_no_write got=%h exp=0000", ram[11'h005]); end
        do_reset();
        checks++; if ({InsAddr, Halted} !== {11'h000, 1'b0}) begin
            errors++; $display("FAIL halt_reset got=%h/%b exp=000/0", InsAddr, Halted); end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        rom[0] = enc(5'd14, 11'h7FF);
        do_reset();
        tick();
        checks++; if (InsAddr !== 11'h7FF) begin errors++; $display("FAIL jmp_top got=%h exp=7ff", InsAddr); end
        tick();
        checks++; if (InsAddr !== 11'h000) begin errors++; $display("FAIL pc_wrap got=%h exp=000", InsAddr); end
    endtask

    // Random programs run against an instruction-set model of the architectural state.
    task automatic test_random();
        logic [10:0] m_pc, a;
        logic [15:0] m_acc, mem, imm, res, ins;
        logic [4:0]  op;
        logic        m_z, m_n, m_halt, st, exp_rd, exp_wr, upd, tk;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 2048; i++) begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'd0 && $urandom_range(0, 15) != 0) op = 5'd31;
                rom[i] = {op, 11'($urandom)};
                ram[i] = 16'($urandom);
            end
            do_reset();
            m_pc = 0; m_acc = 0; m_z = 0; m_n = 0; m_halt = 0;
            for (int c = 0; c < 250; c++) begin
                st = ($urandom_range(0, 4) == 0);
                Stall = st;
                #1;
                ins = rom[m_pc]; op = ins[15:11]; a = ins[10:0];
                mem = ram[a]; imm = {{5{a[10]}}, a};
                exp_rd = !m_halt && (op inside {5'd2, 5'd4, 5'd6, 5'd16, 5'd18, 5'd20});
                exp_wr = !m_halt && !st && op == 5'd1;
                checks++; if ({InsAddr, Halted, In_Data} !== {m_pc, m_halt, m_acc}) begin
                    errors++; $display("FAIL rand_state got=%h/%b/%h exp=%h/%b/%h", InsAddr, Halted, In_Data, m_pc, m_halt, m_acc); end
                checks++; if ({Rd, Wr} !== {exp_rd, exp_wr}) begin
                    errors++; $display("FAIL rand_strobes op=%0d got=%b%b exp=%b%b", op, Rd, Wr, exp_rd, exp_wr); end
                if (!m_halt && !st) begin
                    upd = 1'b1; tk = 1'b0; res = m_acc;
                    case (op)
                        5'd2:  res = mem;
                        5'd3:  res = imm;
                        5'd4:  res = m_acc + mem;
                        5'd5:  res = m_acc + imm;
                        5'd6:  res = m_acc - mem;
                        5'd7:  res = m_acc - imm;
                        5'd15: res = ~m_acc;
                        5'd16: res = m_acc & mem;
                        5'd17: res = m_acc & imm;
                        5'd18: res = m_acc | mem;
                        5'd19: res = m_acc | imm;
                        5'd20: res = m_acc ^ mem;
                        5'd21: res = m_acc ^ imm;
                        default: upd = 1'b0;
                    endcase
                    case (op)
                        5'd8:  tk = m_z;
                        5'd9:  tk = !m_z;
                        5'd10: tk = !m_z && !m_n;
                        5'd11: tk = !m_n;
                        5'd12: tk = m_n;
                        5'd13: tk = m_n || m_z;
                        5'd14: tk = 1'b1;
                        default: tk = 1'b0;
                    endcase
                    if (upd) begin m_acc = res; m_z = (res == 16'h0000); m_n = res[15]; end
                    if (op == 5'd0) m_halt = 1'b1;
                    else m_pc = tk ? a : m_pc + 11'd1;
                end
                tick();
            end
        end
        Stall = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0;
        test_reset();
        test_flags_wrap();
        test_sto_branch(11'd5);
        test_sto_branch(11'd4);
        test_ld_branch();
        test_stall();
        test_halt();
        test_pc_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
